// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: RUN/SET timekeeping FSM sequencing csec/sec/min/hour counters from a 100 Hz tick
module clock_time_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int INIT_HOUR     = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_tick,
  input  logic                             i_btn_mode,
  input  logic                             i_btn_sel,
  input  logic                             i_btn_up,
  input  logic                             i_btn_down,
  output logic                             o_tick_en,
  output logic                             o_edit,
  output logic [1:0]                       o_field,
  output logic [$clog2(TICKS_PER_SEC)-1:0] o_csec,
  output logic [5:0]                       o_sec,
  output logic [5:0]                       o_min,
  output logic [4:0]                       o_hour,
  output logic                             o_sec_pulse
);
  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] CSEC_MAX = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] CSEC_ONE = CW'(1);
  localparam logic [4:0] HOUR_INIT = 5'(INIT_HOUR);
  localparam logic [1:0] F_HOUR = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_SEC  = 2'd2;
  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;
  state_t          state_q, state_d;
  logic [1:0]      field_q, field_d;
  logic [CW-1:0]   csec_q, csec_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hour_q, hour_d;
  logic            pulse_q, pulse_d;
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction
  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction
  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction
  function automatic logic [4:0] dec24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction
  // next state: ticks with carry chain in RUN, prioritized button edits in SET
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    csec_d  = csec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    pulse_d = 1'b0;
    if (state_q == RUN) begin
      if (i_tick) begin
        csec_d = (csec_q == CSEC_MAX) ? '0 : csec_q + CSEC_ONE;
        if (csec_q == CSEC_MAX) begin
          pulse_d = 1'b1;
          sec_d   = inc60(sec_q);
          if (sec_q == 6'd59) begin
            min_d = inc60(min_q);
            if (min_q == 6'd59) hour_d = inc24(hour_q);
          end
        end
      end
      if (i_btn_mode) begin
        state_d = SET;
        field_d = F_HOUR;
      end
    end else if (i_btn_mode) begin
      state_d = RUN;
      field_d = F_HOUR;
      csec_d  = '0;
    end else if (i_btn_sel) begin
      field_d = (field_q == F_SEC) ? F_HOUR : field_q + 2'd1;
    end else if (i_btn_up ^ i_btn_down) begin
      if (field_q == F_HOUR) hour_d = i_btn_up ? inc24(hour_q) : dec24(hour_q);
      if (field_q == F_MIN)  min_d  = i_btn_up ? inc60(min_q)  : dec60(min_q);
      if (field_q == F_SEC)  sec_d  = i_btn_up ? inc60(sec_q)  : dec60(sec_q);
    end
  end
  // state and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      field_q <= F_HOUR;
      csec_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= HOUR_INIT;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      csec_q  <= csec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pulse_q <= pulse_d;
    end
  end
  assign o_tick_en   = (state_q == RUN);
  assign o_edit      = (state_q == SET);
  assign o_field     = field_q;
  assign o_csec      = csec_q;
  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hour      = hour_q;
  assign o_sec_pulse = pulse_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: vector table, directed corner sequences and random run against a time-of-day model
module tb_clock_time_ctrl;
  localparam int TPS = 100;
  localparam int IH  = 12;
  localparam int DAY = 24 * 3600 * TPS;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_tick = 1'b0, i_btn_mode = 1'b0, i_btn_sel = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
  logic o_tick_en, o_edit, o_sec_pulse;
  logic [1:0] o_field;
  logic [$clog2(TPS)-1:0] o_csec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  int checks = 0;
  int errors = 0;
  int m_t;
  bit m_run;
  int m_fld;
  bit m_pulse;
  clock_time_ctrl #(.TICKS_PER_SEC(TPS), .INIT_HOUR(IH)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_mode(i_btn_mode), .i_btn_sel(i_btn_sel),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down), .o_tick_en(o_tick_en), .o_edit(o_edit),
    .o_field(o_field), .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_sec_pulse(o_sec_pulse)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Reference model: time held as centiseconds since midnight
  task automatic model(input bit r, tk, md, sl, u, dn);
    int h, mi, s, cs, d;
    if (!r) begin
      m_t = IH * 3600 * TPS; m_run = 1; m_fld = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (m_run) begin
      if (tk) begin
        m_t = (m_t + 1) % DAY;
        m_pulse = (m_t % TPS) == 0;
      end
      if (md) begin m_run = 0; m_fld = 0; end
    end else if (md) begin
      m_run = 1; m_fld = 0; m_t = m_t - m_t % TPS;
    end else if (sl) begin
      m_fld = (m_fld + 1) % 3;
    end else if (u != dn) begin
      d = u ? 1 : -1;
      cs = m_t % TPS; s = (m_t / TPS) % 60; mi = (m_t / (60 * TPS)) % 60; h = m_t / (3600 * TPS);
      if (m_fld == 0) h = (h + d + 24) % 24;
      if (m_fld == 1) mi = (mi + d + 60) % 60;
      if (m_fld == 2) s = (s + d + 60) % 60;
      m_t = ((h * 60 + mi) * 60 + s) * TPS + cs;
    end
  endtask
  task automatic step(input bit r, tk, md, sl, u, dn);
    rst = r; i_tick = tk; i_btn_mode = md; i_btn_sel = sl; i_btn_up = u; i_btn_down = dn;
    @(posedge clk);
    #1;
    model(r, tk, md, sl, u, dn);
    check("m_tick_en", int'(o_tick_en), int'(m_run));
    check("m_edit", int'(o_edit), int'(!m_run));
    check("m_field", int'(o_field), m_fld);
    check("m_csec", int'(o_csec), m_t % TPS);
    check("m_sec", int'(o_sec), (m_t / TPS) % 60);
    check("m_min", int'(o_min), (m_t / (60 * TPS)) % 60);
    check("m_hour", int'(o_hour), m_t / (3600 * TPS));
    check("m_pulse", int'(o_sec_pulse), int'(m_pulse));
  endtask
  task automatic expect_time(input string name, input int h, mi, s, cs);
    check({name, "_hour"}, int'(o_hour), h);
    check({name, "_min"}, int'(o_min), mi);
    check({name, "_sec"}, int'(o_sec), s);
    check({name, "_csec"}, int'(o_csec), cs);
  endtask
  typedef struct {
    bit r, tk, md, sl, u, dn;
    int hour, min, sec, csec, edit, field, pulse;
  } vec_t;
  vec_t vt[13];
  initial begin
    int pulses;
    vt[0]  = '{0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0};
    vt[2]  = '{1, 0, 1, 0, 0, 0, 12, 0, 0, 1, 1, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 0, 0, 12, 0, 0, 1, 1, 0, 0};
    vt[4]  = '{1, 0, 0, 0, 0, 1, 11, 0, 0, 1, 1, 0, 0};
    vt[5]  = '{1, 0, 0, 0, 1, 1, 11, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{1, 0, 0, 1, 1, 0, 11, 0, 0, 1, 1, 1, 0};
    vt[7]  = '{1, 0, 0, 0, 0, 1, 11, 59, 0, 1, 1, 1, 0};
    vt[8]  = '{1, 0, 0, 0, 1, 0, 11, 0, 0, 1, 1, 1, 0};
    vt[9]  = '{1, 0, 0, 1, 0, 0, 11, 0, 0, 1, 1, 2, 0};
    vt[10] = '{1, 0, 0, 1, 0, 0, 11, 0, 0, 1, 1, 0, 0};
    vt[11] = '{1, 0, 1, 1, 0, 0, 11, 0, 0, 0, 0, 0, 0};
    vt[12] = '{1, 1, 0, 0, 0, 0, 11, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].tk, vt[i].md, vt[i].sl, vt[i].u, vt[i].dn);
      expect_time($sformatf("vec%0d", i), vt[i].hour, vt[i].min, vt[i].sec, vt[i].csec);
      check($sformatf("vec%0d_edit", i), int'(o_edit), vt[i].edit);
      check($sformatf("vec%0d_tick_en", i), int'(o_tick_en), 1 - vt[i].edit);
      check($sformatf("vec%0d_field", i), int'(o_field), vt[i].field);
      check($sformatf("vec%0d_pulse", i), int'(o_sec_pulse), vt[i].pulse);
    end
    // 100 ticks from reset: csec walks 0..99, then one-second carry
    step(0, 1, 1, 1, 1, 0);
    expect_time("rst", 12, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= TPS; i++) begin
      step(1, 1, 0, 0, 0, 0);
      pulses += int'(o_sec_pulse);
      if (i < TPS) check("walk_csec", int'(o_csec), i);
    end
    expect_time("carry", 12, 0, 1, 0);
    check("carry_pulse", int'(o_sec_pulse), 1);
    step(1, 0, 0, 0, 0, 0);
    pulses += int'(o_sec_pulse);
    check("pulse_count", pulses, 1);
    // preload 23:59:59 through SET, then full-day rollover
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    expect_time("preload", 23, 59, 59, 0);
    for (int i = 0; i < TPS - 1; i++) step(1, 1, 0, 0, 0, 0);
    expect_time("pre_roll", 23, 59, 59, TPS - 1);
    step(1, 1, 0, 0, 0, 0);
    expect_time("roll", 0, 0, 0, 0);
    check("roll_pulse", int'(o_sec_pulse), 1);
    // enter SET at .37, ticks ignored
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 37; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("set_edit", int'(o_edit), 1);
    check("set_tick_en", int'(o_tick_en), 0);
    for (int i = 0; i < 50; i++) step(1, 1, 0, 0, 0, 0);
    expect_time("set_hold", 12, 0, 0, 37);
    // tick and mode together: carry applied before entering SET
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TPS - 1; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    expect_time("tick_mode", 12, 0, 1, 0);
    check("tick_mode_edit", int'(o_edit), 1);
    // reset during SET with edited 05:17:00 discards edits
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 1, 0);
    expect_time("edited", 5, 17, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    expect_time("mid_rst", 12, 0, 0, 0);
    check("mid_rst_edit", int'(o_edit), 0);
    check("mid_rst_tick_en", int'(o_tick_en), 1);
    check("mid_rst_field", int'(o_field), 0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) != 0, $urandom_range(1) == 1, $urandom_range(15) == 0,
           $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping controller for the digital clock. It consumes the 100 Hz tick from the tick generator and sequences the centisecond/second/minute/hour counters.
- It gates the tick generator through o_tick_en and runs a RUN/SET mode FSM so the user can edit hours, minutes and seconds with debounced button pulses.
- Its outputs feed the display/FND formatting logic.

Parameters:
- TICKS_PER_SEC, 100, i_tick pulses per second; the centisecond field counts 0..TICKS_PER_SEC-1.
- INIT_HOUR, 12, hour value loaded at reset (0..23).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-low. Sampled on the rising edge of clk; when low, all state is reset.
- i_tick  input  1  one-cycle pulse from the tick generator.
- i_btn_mode  input  1  one-cycle debounced pulse; toggles RUN/SET.
- i_btn_sel  input  1  one-cycle pulse; advances the edit field in SET.
- i_btn_up  input  1  one-cycle pulse; increments the selected field in SET.
- i_btn_down  input  1  one-cycle pulse; decrements the selected field in SET.
- o_tick_en  output  1  enable for the tick generator: 1 in RUN, 0 in SET.
- o_edit  output  1  1 while in SET.
- o_field  output  2  selected field: 0=HOUR, 1=MIN, 2=SEC, 3 unused/never driven.
- o_csec  output  $clog2(TICKS_PER_SEC)  centiseconds.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_sec_pulse  output  1  one-cycle pulse when o_sec changes due to a tick carry.

Behaviour:
- All outputs are registered.
- Reset values:
  - state RUN, o_tick_en=1, o_edit=0, o_field=0
  - o_csec=0, o_sec=0, o_min=0, o_hour=INIT_HOUR, o_sec_pulse=0
- FSM states: RUN and SET.
- RUN:
  - i_tick=1 increments o_csec; updated values are visible the cycle after i_tick is sampled.
  - o_csec==TICKS_PER_SEC-1 with a tick: o_csec wraps to 0, o_sec increments, o_sec_pulse=1 for that update cycle.
  - o_sec==59 carry: wraps to 0, o_min increments. o_min==59 carry: wraps to 0, o_hour increments. o_hour==23 carry: wraps to 0.
  - Rollover: 23:59:59.(TICKS_PER_SEC-1) plus a tick gives 00:00:00.00 in a single cycle.
  - i_btn_sel, i_btn_up and i_btn_down are ignored.
- RUN -> SET on i_btn_mode:
  - If i_tick is high in the same cycle, the tick (including carries) is applied first, then the state changes.
  - On entry: o_field=HOUR, o_edit=1, o_tick_en=0.
- SET:
  - i_tick is ignored; all counters hold.
  - Button priority: mode > sel > up/down. Only the highest-priority asserted action takes effect per cycle.
  - i_btn_sel: o_field advances 0->1->2->0.
  - i_btn_up: selected field +1 with wrap (hour 23->0, min/sec 59->0), no carry into other fields.
  - i_btn_down: selected field -1 with wrap (hour 0->23, min/sec 0->59), no borrow.
  - i_btn_up and i_btn_down together: no change.
  - o_sec_pulse stays 0 in SET, including for edits.
- SET -> RUN on i_btn_mode:
  - o_csec cleared to 0, o_field reset to 0, o_edit=0, o_tick_en=1 next cycle.
  - Edited hour/min/sec are retained.
- Reset mid-operation (any state, any button or tick activity): next cycle equals the reset values above. Pending edits are discarded.
- Counter width: internal compares use full-width constants; o_csec must never reach TICKS_PER_SEC.
- Button inputs are assumed single-cycle. A held high level acts as one pulse per cycle.

Test Plan:
- Reset, then 100 i_tick pulses -> o_csec 0..99 then 0; o_sec=1; o_sec_pulse high exactly one cycle; o_hour=12.
- Preload via SET to 23:59:59, exit SET, apply 100 ticks -> 00:00:00.00 in one update cycle; o_sec_pulse=1.
- RUN at 12:00:00.37, i_btn_mode -> o_edit=1, o_tick_en=0, o_field=0; apply 50 ticks -> time unchanged.
- SET at HOUR=0, i_btn_down -> 23. i_btn_sel, then i_btn_up from MIN=59 -> 0 with hour unchanged. i_btn_up+i_btn_down together -> no change.
- SET: i_btn_mode and i_btn_sel in the same cycle -> state RUN, o_field=0, o_csec=0, o_tick_en=1 next cycle.
- In SET with edited time 05:17:00, pull rst low for 1 cycle -> 12:00:00.00, RUN, o_tick_en=1, o_edit=0.
